// File: rtl/key_scanner.sv
// Four-key debounced scanner: 2-flop synchronizer, debounce FSM with press/release
// acceptance pulses, one-hot/binary key outputs and a multi-press flag.
module key_scanner #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    output logic [3:0] key_onehot,
    output logic [1:0] key_code,
    output logic       key_valid,
    output logic       key_release,
    output logic       multi_press,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [7:0] N_CYC = 8'(DEBOUNCE_CYCLES);

    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    state_t     r_state;
    logic [7:0] r_cnt;
    logic [3:0] r_cand;
    logic [3:0] r_key_onehot;
    logic [1:0] r_key_code;
    logic       r_key_valid;
    logic       r_key_release;
    logic       r_multi;

    state_t     w_state_nx;
    logic [7:0] w_cnt_nx;
    logic [3:0] w_cand_nx;
    logic [3:0] w_onehot_nx;
    logic [1:0] w_code_nx;
    logic       w_valid_nx;
    logic       w_release_nx;
    logic [7:0] w_cnt_inc;
    logic       w_multi;
    logic       w_single;
    logic [1:0] w_cand_code;

    // x & (x-1) clears the lowest set bit, so a nonzero result means two or more bits.
    assign w_multi   = (r_sync2 & (r_sync2 - 4'd1)) != 4'd0;
    assign w_single  = (r_sync2 != 4'd0) && !w_multi;
    assign w_cnt_inc = r_cnt + 8'd1;

    always_comb begin
        w_cand_code = 2'd0;
        case (r_cand)
            4'b0010: w_cand_code = 2'd1;
            4'b0100: w_cand_code = 2'd2;
            4'b1000: w_cand_code = 2'd3;
            default: w_cand_code = 2'd0;
        endcase
    end

    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_cand_nx    = r_cand;
        w_onehot_nx  = r_key_onehot;
        w_code_nx    = r_key_code;
        w_valid_nx   = 1'b0;
        w_release_nx = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_single) begin
                    w_cand_nx  = r_sync2;
                    w_cnt_nx   = 8'd1;
                    w_state_nx = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (r_sync2 == r_cand) begin
                    if (w_cnt_inc == N_CYC) begin
                        w_cnt_nx    = 8'd0;
                        w_state_nx  = PRESSED;
                        w_onehot_nx = r_cand;
                        w_code_nx   = w_cand_code;
                        w_valid_nx  = 1'b1;
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end else begin
                    w_cnt_nx   = 8'd0;
                    w_state_nx = IDLE;
                end
            end
            PRESSED: begin
                if (r_sync2 == 4'd0) begin
                    w_cnt_nx   = 8'd1;
                    w_state_nx = RELEASE;
                end
            end
            RELEASE: begin
                if (r_sync2 == 4'd0) begin
                    if (w_cnt_inc == N_CYC) begin
                        w_cnt_nx     = 8'd0;
                        w_state_nx   = IDLE;
                        w_onehot_nx  = 4'd0;
                        w_code_nx    = 2'd0;
                        w_release_nx = 1'b1;
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end else begin
                    w_cnt_nx   = 8'd0;
                    w_state_nx = PRESSED;
                end
            end
            default: begin
                w_cnt_nx   = 8'd0;
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1       <= 4'd0;
            r_sync2       <= 4'd0;
            r_state       <= IDLE;
            r_cnt         <= 8'd0;
            r_cand        <= 4'd0;
            r_key_onehot  <= 4'd0;
            r_key_code    <= 2'd0;
            r_key_valid   <= 1'b0;
            r_key_release <= 1'b0;
            r_multi       <= 1'b0;
        end else begin
            r_sync1       <= btn;
            r_sync2       <= r_sync1;
            r_state       <= w_state_nx;
            r_cnt         <= w_cnt_nx;
            r_cand        <= w_cand_nx;
            r_key_onehot  <= w_onehot_nx;
            r_key_code    <= w_code_nx;
            r_key_valid   <= w_valid_nx;
            r_key_release <= w_release_nx;
            r_multi       <= w_multi;
        end
    end

    assign key_onehot  = r_key_onehot;
    assign key_code    = r_key_code;
    assign key_valid   = r_key_valid;
    assign key_release = r_key_release;
    assign multi_press = r_multi;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_key_scanner.sv
// Directed bench for key_scanner (DEBOUNCE_CYCLES=4): press/release latency, bounce,
// multi-press, held-key change and reset aborts.
module tb_key_scanner;

    logic       clk;
    logic       reset;
    logic [3:0] btn;
    logic [3:0] key_onehot;
    logic [1:0] key_code;
    logic       key_valid;
    logic       key_release;
    logic       multi_press;
    logic [1:0] dbg_state;

    int n_checks;
    int n_errors;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PRESSED = 2'd2;

    key_scanner #(.DEBOUNCE_CYCLES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .btn         (btn),
        .key_onehot  (key_onehot),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_release (key_release),
        .multi_press (multi_press),
        .dbg_state   (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then sample 1 time unit later; invariants checked every cycle.
    task automatic tick();
        logic [3:0] oh;
        @(posedge clk);
        #1;
        oh = key_onehot;
        chk("valid_release_excl", {7'd0, key_valid & key_release}, 8'd0);
        chk("onehot_legal", {7'd0, (oh & (oh - 4'd1)) != 4'd0}, 8'd0);
    endtask

    task automatic do_press(input string tag, input logic [3:0] b, input logic [3:0] oh,
                            input logic [1:0] code);
        btn = b;
        for (int e = 1; e <= 7; e++) begin
            tick();
            chk({tag, "_valid"}, {7'd0, key_valid}, (e == 6) ? 8'd1 : 8'd0);
            chk({tag, "_rel"}, {7'd0, key_release}, 8'd0);
            if (e == 6) begin
                chk({tag, "_onehot"}, {4'd0, key_onehot}, {4'd0, oh});
                chk({tag, "_code"}, {6'd0, key_code}, {6'd0, code});
                chk({tag, "_state"}, {6'd0, dbg_state}, {6'd0, S_PRESSED});
            end
        end
    endtask

    task automatic do_release(input string tag, input logic [3:0] held);
        btn = 4'd0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            chk({tag, "_rel"}, {7'd0, key_release}, (e == 6) ? 8'd1 : 8'd0);
            chk({tag, "_valid"}, {7'd0, key_valid}, 8'd0);
            chk({tag, "_onehot"}, {4'd0, key_onehot}, (e >= 6) ? 8'd0 : {4'd0, held});
        end
        chk({tag, "_code"}, {6'd0, key_code}, 8'd0);
        chk({tag, "_state"}, {6'd0, dbg_state}, {6'd0, S_IDLE});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        btn = 4'd0;
        tick();
        tick();
        chk("rst_onehot", {4'd0, key_onehot}, 8'd0);
        chk("rst_code", {6'd0, key_code}, 8'd0);
        chk("rst_valid", {7'd0, key_valid}, 8'd0);
        chk("rst_release", {7'd0, key_release}, 8'd0);
        chk("rst_multi", {7'd0, multi_press}, 8'd0);
        chk("rst_state", {6'd0, dbg_state}, {6'd0, S_IDLE});
        reset = 1'b0;
        tick();

        // Clean press, held for 10 cycles total, then released.
        do_press("clean", 4'b0100, 4'b0100, 2'd2);
        for (int i = 0; i < 3; i++) tick();
        chk("clean_hold_onehot", {4'd0, key_onehot}, 8'h04);
        do_release("clean_rel", 4'b0100);

        // Bounce: 3 cycles high, 1 low, then held.
        btn = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bounce_a_valid", {7'd0, key_valid}, 8'd0);
        end
        btn = 4'b0000;
        tick();
        chk("bounce_b_valid", {7'd0, key_valid}, 8'd0);
        do_press("bounce", 4'b0001, 4'b0001, 2'd0);
        do_release("bounce_rel", 4'b0001);

        // Multi-press held from IDLE, then a single key.
        btn = 4'b0011;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk("multi_flag", {7'd0, multi_press}, (e >= 3) ? 8'd1 : 8'd0);
            chk("multi_valid", {7'd0, key_valid}, 8'd0);
            chk("multi_state", {6'd0, dbg_state}, {6'd0, S_IDLE});
        end
        do_press("multi_single", 4'b0010, 4'b0010, 2'd1);
        chk("multi_clear", {7'd0, multi_press}, 8'd0);
        do_release("multi_rel", 4'b0010);

        // Held-key change is ignored until a full release.
        do_press("held", 4'b0001, 4'b0001, 2'd0);
        btn = 4'b0010;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("held_chg_valid", {7'd0, key_valid}, 8'd0);
            chk("held_chg_onehot", {4'd0, key_onehot}, 8'h01);
            chk("held_chg_code", {6'd0, key_code}, 8'd0);
        end
        do_release("held_rel", 4'b0001);
        do_press("held_new", 4'b0010, 4'b0010, 2'd1);
        do_release("held_new_rel", 4'b0010);

        // Press key 3, release bounce returns to PRESSED silently, then full release.
        do_press("k3", 4'b1000, 4'b1000, 2'd3);
        btn = 4'b0000;
        tick();
        tick();
        btn = 4'b1000;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("relbounce_rel", {7'd0, key_release}, 8'd0);
            chk("relbounce_onehot", {4'd0, key_onehot}, 8'h08);
        end
        chk("relbounce_state", {6'd0, dbg_state}, {6'd0, S_PRESSED});
        do_release("k3_rel", 4'b1000);

        // Reset at edge 4 of a press; key still held afterwards is a fresh press.
        btn = 4'b0100;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstdeb_valid", {7'd0, key_valid}, 8'd0);
        chk("rstdeb_state", {6'd0, dbg_state}, {6'd0, S_IDLE});
        do_press("rstdeb", 4'b0100, 4'b0100, 2'd2);

        // Reset mid-release aborts with no pulse and clears outputs.
        btn = 4'b0000;
        tick();
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstrel_onehot", {4'd0, key_onehot}, 8'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rstrel_rel", {7'd0, key_release}, 8'd0);
            chk("rstrel_valid", {7'd0, key_valid}, 8'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
